// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage and its decoder neighbour.
package instruction_fetch_pkg;

  localparam int unsigned INSN_W     = 24;
  localparam int unsigned LEN_W      = 2;
  localparam int unsigned OPC_LEN_HI = 7;
  localparam int unsigned OPC_LEN_LO = 6;

  typedef enum logic [1:0] {
    S_START   = 2'd0,
    S_WAIT    = 2'd1,
    S_PRESENT = 2'd2
  } fetch_state_e;

  // Raw opcode[7:6] length field
  typedef enum logic [1:0] {
    OPL_1    = 2'b00,
    OPL_2    = 2'b01,
    OPL_3    = 2'b10,
    OPL_RSVD = 2'b11
  } opc_len_e;

  localparam logic [LEN_W-1:0] LEN_1 = 2'd1;
  localparam logic [LEN_W-1:0] LEN_2 = 2'd2;
  localparam logic [LEN_W-1:0] LEN_3 = 2'd3;

endpackage

// File: rtl/instruction_fetch_if.sv
// ROM bus, redirect and decoder handshake signals of the fetch stage.
interface instruction_fetch_if
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CS_bar;
  logic                  OE_bar;
  logic                  WE_bar;
  logic [7:0]            D;
  logic                  JUMP;
  logic [ADDR_WIDTH-1:0] JUMP_ADDR;
  logic [INSN_W-1:0]     INSN;
  logic [LEN_W-1:0]      INSN_LEN;
  logic [ADDR_WIDTH-1:0] INSN_PC;
  logic                  VALID;
  logic                  READY;

  modport master (
    output A, CS_bar, OE_bar, WE_bar, INSN, INSN_LEN, INSN_PC, VALID,
    input  D, JUMP, JUMP_ADDR, READY
  );

  modport slave (
    input  A, CS_bar, OE_bar, WE_bar, INSN, INSN_LEN, INSN_PC, VALID,
    output D, JUMP, JUMP_ADDR, READY
  );
endinterface

// File: rtl/instruction_fetch_insn_length_decode.sv
// Opcode length field to instruction byte count (1..3); reserved encoding is one byte.
module instruction_fetch_insn_length_decode
  import instruction_fetch_pkg::*;
(
  input  logic [1:0]       len_field,
  output logic [LEN_W-1:0] len_c
);

  always_comb begin
    len_c = LEN_1;
    case (opc_len_e'(len_field))
      OPL_2:   len_c = LEN_2;
      OPL_3:   len_c = LEN_3;
      default: len_c = LEN_1;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Program-ROM fetch stage: walks the PC, waits the ROM access time per byte,
// assembles 1-3 byte instructions and presents them over VALID/READY.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned RESET_VECTOR = 0
) (
  input logic                 CLK,
  input logic                 RST,
  instruction_fetch_if.master bus
);

  localparam int unsigned           CNT_W      = 4;
  localparam logic [CNT_W-1:0]      CNT_RELOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] PC_RESET   = ADDR_WIDTH'(RESET_VECTOR);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [LEN_W-1:0]      tgt_q, tgt_d;
  logic                  valid_q, valid_d;
  logic [INSN_W-1:0]     insn_q, insn_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] insn_pc_q, insn_pc_d;

  logic [LEN_W-1:0]      dec_len_c;
  logic [LEN_W-1:0]      eff_len_c;

  instruction_fetch_insn_length_decode u_len_dec (
    .len_field (bus.D[OPC_LEN_HI:OPC_LEN_LO]),
    .len_c     (dec_len_c)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_START;
      pc_q      <= PC_RESET;
      cnt_q     <= CNT_RELOAD;
      idx_q     <= 2'd0;
      tgt_q     <= '0;
      valid_q   <= 1'b0;
      insn_q    <= '0;
      len_q     <= '0;
      insn_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tgt_q     <= tgt_d;
      valid_q   <= valid_d;
      insn_q    <= insn_d;
      len_q     <= len_d;
      insn_pc_q <= insn_pc_d;
    end
  end

  // Opcode byte supplies the length; later bytes reuse the captured one
  always_comb begin
    eff_len_c = (idx_q == 2'd0) ? dec_len_c : tgt_q;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tgt_d     = tgt_q;
    valid_d   = valid_q;
    insn_d    = insn_q;
    len_d     = len_q;
    insn_pc_d = insn_pc_q;

    // Redirect beats everything, including a coincident handshake
    if (bus.JUMP) begin
      pc_d    = bus.JUMP_ADDR;
      valid_d = 1'b0;
      idx_d   = 2'd0;
      cnt_d   = CNT_RELOAD;
      state_d = S_WAIT;
    end else begin
      case (state_q)
        S_START: begin
          cnt_d   = CNT_RELOAD;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            pc_d = pc_q + ADDR_WIDTH'(1);
            case (idx_q)
              2'd0: begin
                insn_d    = {16'h0000, bus.D};
                insn_pc_d = pc_q;
                tgt_d     = dec_len_c;
              end
              2'd1:    insn_d[15:8]  = bus.D;
              default: insn_d[23:16] = bus.D;
            endcase
            if ((idx_q + 2'd1) == eff_len_c) begin
              valid_d = 1'b1;
              len_d   = eff_len_c;
              state_d = S_PRESENT;
            end else begin
              idx_d = idx_q + 2'd1;
              cnt_d = CNT_RELOAD;
            end
          end
        end
        S_PRESENT: begin
          if (bus.READY) begin
            valid_d = 1'b0;
            idx_d   = 2'd0;
            cnt_d   = CNT_RELOAD;
            state_d = S_WAIT;
          end
        end
        default: state_d = S_START;
      endcase
    end
  end

  assign bus.A        = pc_q;
  assign bus.CS_bar   = (state_q != S_WAIT);
  assign bus.OE_bar   = (state_q != S_WAIT);
  assign bus.WE_bar   = 1'b1;
  assign bus.INSN     = insn_q;
  assign bus.INSN_LEN = len_q;
  assign bus.INSN_PC  = insn_pc_q;
  assign bus.VALID    = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch against a behavioural ROM model.
module tb_instruction_fetch;

  localparam int unsigned AW = 15;

  logic CLK;
  logic RST;
  logic [7:0] rom [0:32767];

  int vectors;
  int miscompares;
  int lat;

  instruction_fetch_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_fetch #(
    .ADDR_WIDTH   (AW),
    .WAIT_CYCLES  (2),
    .RESET_VECTOR (0)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  assign bus.D = (!bus.CS_bar && !bus.OE_bar) ? rom[bus.A] : 8'hzz;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Cycles until VALID is seen, capped so a dead DUT cannot hang the run
  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.VALID && n < max);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 32768; i++) rom[i] = 8'h00;
    rom[0]      = 8'h05;
    rom[1]      = 8'h8A;
    rom[2]      = 8'h34;
    rom[3]      = 8'h12;
    rom[4]      = 8'h00;
    rom[5]      = 8'h9C;
    rom[6]      = 8'h11;
    rom[7]      = 8'h22;
    rom[16'h100] = 8'h47;
    rom[16'h101] = 8'h55;
    rom[16'h7FFF] = 8'h41;

    RST           = 1'b1;
    bus.READY     = 1'b0;
    bus.JUMP      = 1'b0;
    bus.JUMP_ADDR = '0;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_cs", 32'(bus.CS_bar), 32'h1);
    chk("rst_oe", 32'(bus.OE_bar), 32'h1);
    chk("rst_we", 32'(bus.WE_bar), 32'h1);
    chk("rst_valid", 32'(bus.VALID), 32'h0);
    chk("rst_insn", 32'(bus.INSN), 32'h0);
    chk("rst_len", 32'(bus.INSN_LEN), 32'h0);
    chk("rst_a", 32'(bus.A), 32'h0);
    RST = 1'b0;

    // First single-byte fetch
    step();
    chk("t1_cs_fall", 32'(bus.CS_bar), 32'h0);
    chk("t1_oe_fall", 32'(bus.OE_bar), 32'h0);
    wait_valid(50, lat);
    chk("t1_lat", 32'(lat), 32'd3);
    chk("t1_insn", 32'(bus.INSN), 32'h000005);
    chk("t1_len", 32'(bus.INSN_LEN), 32'd1);
    chk("t1_pc", 32'(bus.INSN_PC), 32'h0);
    chk("t1_a", 32'(bus.A), 32'h1);
    chk("t1_cs_present", 32'(bus.CS_bar), 32'h1);

    // Three-byte fetch
    bus.READY = 1'b1;
    step();
    bus.READY = 1'b0;
    chk("t2_valid_drop", 32'(bus.VALID), 32'h0);
    wait_valid(50, lat);
    chk("t2_lat", 32'(lat), 32'd9);
    chk("t2_insn", 32'(bus.INSN), 32'h12348A);
    chk("t2_len", 32'(bus.INSN_LEN), 32'd3);
    chk("t2_pc", 32'(bus.INSN_PC), 32'h1);
    chk("t2_a", 32'(bus.A), 32'h4);

    // Stall with READY low
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stall_valid", 32'(bus.VALID), 32'h1);
      chk("stall_insn", 32'(bus.INSN), 32'h12348A);
      chk("stall_pc", 32'(bus.INSN_PC), 32'h1);
      chk("stall_a", 32'(bus.A), 32'h4);
      chk("stall_cs", 32'(bus.CS_bar), 32'h1);
    end
    bus.READY = 1'b1;
    step();
    bus.READY = 1'b0;
    wait_valid(50, lat);
    chk("t3_lat", 32'(lat), 32'd3);
    chk("t3_insn", 32'(bus.INSN), 32'h000000);
    chk("t3_len", 32'(bus.INSN_LEN), 32'd1);
    chk("t3_pc", 32'(bus.INSN_PC), 32'h4);
    chk("t3_a", 32'(bus.A), 32'h5);

    // Redirect during second byte of a three-byte fetch
    bus.READY = 1'b1;
    step();
    bus.READY = 1'b0;
    step();
    step();
    step();
    step();
    chk("t4_mid_a", 32'(bus.A), 32'h6);
    chk("t4_mid_valid", 32'(bus.VALID), 32'h0);
    bus.JUMP      = 1'b1;
    bus.JUMP_ADDR = 15'h0100;
    step();
    bus.JUMP = 1'b0;
    chk("t4_jmp_a", 32'(bus.A), 32'h100);
    chk("t4_jmp_valid", 32'(bus.VALID), 32'h0);
    wait_valid(50, lat);
    chk("t4_lat", 32'(lat), 32'd6);
    chk("t4_insn", 32'(bus.INSN), 32'h005547);
    chk("t4_len", 32'(bus.INSN_LEN), 32'd2);
    chk("t4_pc", 32'(bus.INSN_PC), 32'h100);
    chk("t4_a", 32'(bus.A), 32'h102);

    // Redirect coinciding with handshake, then fetch across the PC wrap
    rom[0] = 8'hEE;
    bus.READY     = 1'b1;
    bus.JUMP      = 1'b1;
    bus.JUMP_ADDR = 15'h7FFF;
    step();
    bus.READY = 1'b0;
    bus.JUMP  = 1'b0;
    chk("t5_jmp_valid", 32'(bus.VALID), 32'h0);
    chk("t5_jmp_a", 32'(bus.A), 32'h7FFF);
    chk("t5_jmp_cs", 32'(bus.CS_bar), 32'h0);
    wait_valid(50, lat);
    chk("t5_lat", 32'(lat), 32'd6);
    chk("t5_insn", 32'(bus.INSN), 32'h00EE41);
    chk("t5_len", 32'(bus.INSN_LEN), 32'd2);
    chk("t5_pc", 32'(bus.INSN_PC), 32'h7FFF);
    chk("t5_a", 32'(bus.A), 32'h1);

    // Asynchronous reset between edges while fetching
    bus.READY = 1'b1;
    step();
    bus.READY = 1'b0;
    chk("t6_wait_cs", 32'(bus.CS_bar), 32'h0);
    step();
    #2;
    RST = 1'b1;
    #1;
    chk("t6_async_cs", 32'(bus.CS_bar), 32'h1);
    chk("t6_async_valid", 32'(bus.VALID), 32'h0);
    chk("t6_async_a", 32'(bus.A), 32'h0);
    chk("t6_async_insn", 32'(bus.INSN), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    wait_valid(50, lat);
    chk("t6_lat", 32'(lat), 32'd4);
    chk("t6_insn", 32'(bus.INSN), 32'h0000EE);
    chk("t6_len", 32'(bus.INSN_LEN), 32'd1);
    chk("t6_pc", 32'(bus.INSN_PC), 32'h0);
    chk("t6_a", 32'(bus.A), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
